// File: rtl/spectrum_shifter_if.sv
// Spectrum shifter bus: frame control, source RAM port and IFFT read port.
// The slave modport is the shifter side; master is the driving environment.
interface spectrum_shifter_if #(
  parameter int ADDR_W  = 9,
  parameter int DW      = 18,
  parameter int RATIO_W = 16
) ();
  logic                 start;
  logic [RATIO_W-1:0]   inv_ratio;
  logic                 busy;
  logic                 done;
  logic [ADDR_W-1:0]    src_addr;
  logic [2*DW-1:0]      src_data;
  logic [ADDR_W-1:0]    result_address;
  logic                 result_read_enable;
  logic [2*DW-1:0]      result_data;
  logic                 result_read_valid;

  modport slave (
    input  start,
    input  inv_ratio,
    input  src_data,
    input  result_address,
    input  result_read_enable,
    output busy,
    output done,
    output src_addr,
    output result_data,
    output result_read_valid
  );

  modport master (
    output start,
    output inv_ratio,
    output src_data,
    output result_address,
    output result_read_enable,
    input  busy,
    input  done,
    input  src_addr,
    input  result_data,
    input  result_read_valid
  );
endinterface

// File: rtl/spectrum_shifter.sv
// Frequency-axis resampler: out[k] = lerp(src, k*inv_ratio), double-buffered
// into a front/back bank pair that the IFFT reads through a registered port.
module spectrum_shifter #(
  parameter int N_BINS  = 512,
  parameter int ADDR_W  = 9,
  parameter int DW      = 18,
  parameter int RATIO_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  spectrum_shifter_if.slave  bus
);

  localparam int FW = 12;
  localparam int IW = ADDR_W + 4;
  localparam int PW = IW + FW;
  localparam int MW = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    MUL,
    WR,
    SWAP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [RATIO_W-1:0]   ratio;
  logic [PW-1:0]        p;
  logic [PW-1:0]        p_step;
  logic [ADDR_W-1:0]    k;
  logic                 bank_sel;

  logic signed [DW-1:0] lo_re;
  logic signed [DW-1:0] lo_im;
  logic signed [MW-1:0] prod_re;
  logic signed [MW-1:0] prod_im;

  logic [IW-1:0]        i_cur;
  logic [IW-1:0]        i_step;
  logic [FW-1:0]        f_cur;
  logic                 oob;
  logic                 last_bin;
  logic [ADDR_W-1:0]    hi_addr;
  logic [2*DW-1:0]      wr_data;
  logic                 k_last;

  logic [2*DW-1:0]      bank [2*N_BINS];

  function automatic logic signed [MW-1:0] lerp_prod(
    input logic signed [DW-1:0] hi,
    input logic signed [DW-1:0] lo,
    input logic [FW-1:0]        f
  );
    logic signed [MW-1:0] d;
    d = MW'(hi) - MW'(lo);
    return d * $signed({{(MW-FW){1'b0}}, f});
  endfunction

  // Arithmetic shift floors the fractional step; the sum always lies
  // between lo and hi, so truncating to DW cannot wrap.
  function automatic logic [DW-1:0] lerp_out(
    input logic signed [DW-1:0] lo,
    input logic signed [MW-1:0] prod
  );
    return DW'(MW'(lo) + (prod >>> FW));
  endfunction

  assign i_cur    = p[PW-1:FW];
  assign f_cur    = p[FW-1:0];
  assign p_step   = p + PW'(ratio);
  assign i_step   = p_step[PW-1:FW];
  assign oob      = |i_cur[IW-1:ADDR_W];
  assign last_bin = (i_cur[ADDR_W-1:0] == ADDR_W'(N_BINS-1));
  assign k_last   = (k == ADDR_W'(N_BINS-1));

  always_comb begin
    hi_addr = i_cur[ADDR_W-1:0] + ADDR_W'(1);
    if (oob || last_bin)
      hi_addr = ADDR_W'(N_BINS-1);
  end

  always_comb begin
    wr_data = '0;
    if (!oob)
      wr_data = {lerp_out(lo_re, prod_re),
                 lerp_out(lo_im, prod_im)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RD_LO;
      RD_LO:   state_nx = RD_HI;
      RD_HI:   state_nx = MUL;
      MUL:     state_nx = WR;
      WR:      state_nx = k_last ? SWAP : RD_LO;
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == SWAP);

  // src_addr is loaded on the edge entering each read state, so the
  // sync RAM returns lo during RD_HI and hi during MUL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio        <= '0;
      p            <= '0;
      k            <= '0;
      bank_sel     <= 1'b0;
      lo_re        <= '0;
      lo_im        <= '0;
      prod_re      <= '0;
      prod_im      <= '0;
      bus.src_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ratio        <= bus.inv_ratio;
            p            <= '0;
            k            <= '0;
            bus.src_addr <= '0;
          end
        end
        RD_LO: begin
          bus.src_addr <= hi_addr;
        end
        RD_HI: begin
          lo_re <= bus.src_data[2*DW-1:DW];
          lo_im <= bus.src_data[DW-1:0];
        end
        MUL: begin
          prod_re <= lerp_prod(bus.src_data[2*DW-1:DW], lo_re, f_cur);
          prod_im <= lerp_prod(bus.src_data[DW-1:0], lo_im, f_cur);
        end
        WR: begin
          k <= k + ADDR_W'(1);
          p <= p_step;
          if (!k_last)
            bus.src_addr <= i_step[ADDR_W-1:0];
        end
        SWAP: begin
          bank_sel <= ~bank_sel;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == WR)
      bank[{~bank_sel, k}] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.result_data       <= '0;
      bus.result_read_valid <= 1'b0;
    end else begin
      bus.result_read_valid <= bus.result_read_enable;
      if (bus.result_read_enable)
        bus.result_data <= bank[{bank_sel, bus.result_address}];
    end
  end

endmodule

// File: tb/tb_spectrum_shifter.sv
// Randomized bench for spectrum_shifter against a direct k*ratio
// interpolation model of each output bin.
module tb_spectrum_shifter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  spectrum_shifter_if bus ();

  spectrum_shifter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [35:0] src_mem [512];
  logic [35:0] exp_front [512];
  logic [35:0] exp_new [512];
  logic [35:0] got [512];
  logic [35:0] last_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) bus.src_data <= src_mem[bus.src_addr];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // out[k] = src at position k*ratio/4096, linearly interpolated.
  task automatic model(input int ratio);
    for (int k = 0; k < 512; k++) begin
      longint pos = longint'(k) * longint'(ratio);
      longint i = pos >>> 12;
      longint f = pos & 64'hFFF;
      longint lr, li, hr, hi, vr, vi;
      vr = 0;
      vi = 0;
      if (i < 512) begin
        lr = $signed(src_mem[i][35:18]);
        li = $signed(src_mem[i][17:0]);
        vr = lr;
        vi = li;
        if (i < 511) begin
          hr = $signed(src_mem[i+1][35:18]);
          hi = $signed(src_mem[i+1][17:0]);
          vr = lr + (((hr - lr) * f) >>> 12);
          vi = li + (((hi - li) * f) >>> 12);
        end
      end
      exp_new[k] = {vr[17:0], vi[17:0]};
    end
  endtask

  task automatic read_bin(input int a, output logic [35:0] d);
    @(negedge clk);
    check("rvalid_idle", 64'(bus.result_read_valid), 64'd0);
    check("rdata_hold", 64'(bus.result_data), 64'(last_rd));
    bus.result_address = 9'(a);
    bus.result_read_enable = 1'b1;
    @(negedge clk);
    bus.result_read_enable = 1'b0;
    check("rvalid", 64'(bus.result_read_valid), 64'd1);
    d = bus.result_data;
    last_rd = d;
  endtask

  task automatic check_frame(input string tag);
    logic [35:0] d;
    for (int k = 0; k < 512; k++) begin
      read_bin(k, d);
      got[k] = d;
      check($sformatf("%s[%0d]", tag, k), 64'(d), 64'(exp_front[k]));
    end
  endtask

  task automatic run_frame(input int ratio, input bit extra);
    int dones = 0;
    int first = 0;
    bus.inv_ratio = 16'(ratio);
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= 2060; n++) begin
      @(negedge clk);
      bus.start = extra && (n == 10 || n == 1000 || n == 2049);
      if (extra && n < 2049) bus.inv_ratio = 16'($urandom);
      if (n == 1) check("busy_rise", 64'(bus.busy), 64'd1);
      if (bus.done) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    bus.start = 1'b0;
    check("done_latency", 64'(first), 64'd2049);
    check("done_count", 64'(dones), 64'd1);
    check("busy_fall", 64'(bus.busy), 64'd0);
  endtask

  task automatic frame(input int ratio, input string tag);
    run_frame(ratio, 1'b0);
    model(ratio);
    exp_front = exp_new;
    check_frame(tag);
  endtask

  task automatic rand_src();
    for (int k = 0; k < 512; k++) src_mem[k] = 36'({$urandom, $urandom});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.inv_ratio = '0;
    bus.result_address = '0;
    bus.result_read_enable = 1'b0;
    last_rd = '0;
    for (int k = 0; k < 512; k++) src_mem[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_src_addr", 64'(bus.src_addr), 64'd0);
    check("rst_rdata", 64'(bus.result_data), 64'd0);
    check("rst_rvalid", 64'(bus.result_read_valid), 64'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 512; k++) src_mem[k] = {18'(k), 18'(-k)};
    frame(16'h1000, "t1");

    // Frame B computed while the previous frame is read back.
    for (int k = 0; k < 512; k++) src_mem[k] = {18'(4 * k), 18'($urandom)};
    fork
      run_frame(16'h0800, 1'b0);
      check_frame("t5_old");
    join
    model(16'h0800);
    exp_front = exp_new;
    check_frame("t2");
    check("t2_re2", 64'(got[2][35:18]), 64'd4);
    check("t2_re3", 64'(got[3][35:18]), 64'd6);
    check("t2_re511", 64'(got[511][35:18]), 64'd1022);

    rand_src();
    frame(16'h2000, "t3");
    check("t3_zero", 64'(got[300]), 64'd0);

    rand_src();
    src_mem[0][35:18] = 18'h3FFFF;
    src_mem[1][35:18] = 18'h00000;
    frame(16'h0800, "t4a");
    check("t4_floor", 64'(got[1][35:18]), 64'h3FFFF);

    src_mem[0][35:18] = 18'h20000;
    src_mem[1][35:18] = 18'h1FFFF;
    frame(16'h0FFF, "t4b");
    check("t4_range", 64'(got[1][35:18]), 64'(18'(131007)));

    rand_src();
    frame(0, "r_zero");
    rand_src();
    frame(int'($urandom_range(16'hFFFF, 0)), "r_any");
    rand_src();
    frame(int'($urandom_range(16'h1800, 16'h0100)), "r_mid");

    // Asynchronous reset in the middle of bin 100.
    bus.inv_ratio = 16'h1000;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (400) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_done", 64'(bus.done), 64'd0);
    check("mid_rvalid", 64'(bus.result_read_valid), 64'd0);
    check("mid_rdata", 64'(bus.result_data), 64'd0);
    check("mid_src_addr", 64'(bus.src_addr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = '0;
    rand_src();
    begin
      int r = int'($urandom_range(16'h1400, 16'h0400));
      run_frame(r, 1'b1);
      model(r);
      exp_front = exp_new;
      check_frame("t6");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
